// File: rtl/lsu_mem_ctrl_if.sv
// Data RAM bus between the load/store unit (master) and the data memory (slave).
// A single request is held on mem_req until the slave answers with a one-cycle mem_ack.
interface lsu_mem_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // valid/ready: mem_req is the valid and stays high with we/addr/be/wdata stable
  // until the first cycle mem_ack is high; mem_rdata is only meaningful in that cycle.
  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one outstanding data-RAM access at a time, byte-lane strobes,
// lane-replicated store data and aligned, sign/zero-extended load data.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_rd_en,
  input  logic               req_wr_en,
  input  logic [3:0]         req_ram_type,
  input  logic               req_sign,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               lsu_stall,
  output logic [31:0]        ld_data,
  output logic               ld_valid,
  output logic               misalign_err,
  output logic               timeout_err,
  lsu_mem_ctrl_if.master     mem,
  output logic [1:0]         dbg_state_o
);

  // Encodings of the decoder's BYTE / HALFWORD / FULLWORD access types.
  localparam logic [3:0] TYPE_BYTE = 4'b0001;
  localparam logic [3:0] TYPE_HALF = 4'b0010;
  localparam logic [3:0] TYPE_WORD = 4'b0100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [3:0]  type_q;
  logic        sign_q;
  logic        tmo_q;
  logic [31:0] ld_data_q;

  logic        is_byte, is_half, is_word;
  logic        req_any, req_illegal, req_go, timeout_hit;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] rd_shift;
  logic [31:0] ld_ext;

  assign is_byte = (req_ram_type == TYPE_BYTE);
  assign is_half = (req_ram_type == TYPE_HALF);
  assign is_word = (req_ram_type == TYPE_WORD);

  // An unknown type is treated as "no access", even if rd/wr are asserted.
  assign req_any     = (req_rd_en | req_wr_en) & (is_byte | is_half | is_word);
  assign req_illegal = req_any & ((req_rd_en & req_wr_en) |
                                  (is_half & req_addr[0]) |
                                  (is_word & (req_addr[1:0] != 2'b00)));
  assign req_go      = req_any & ~req_illegal;

  assign timeout_hit = (state_q == ACCESS) & ~mem.mem_ack &
                       (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = req_wdata;
    if (is_byte) begin
      be_calc    = 4'b0001 << req_addr[1:0];
      wdata_calc = {4{req_wdata[7:0]}};
    end else if (is_half) begin
      be_calc    = 4'b0011 << {req_addr[1], 1'b0};
      wdata_calc = {2{req_wdata[15:0]}};
    end
  end

  always_comb begin
    rd_shift = mem.mem_rdata >> {addr_q[1:0], 3'b000};
    ld_ext   = rd_shift;
    if (type_q == TYPE_BYTE) begin
      ld_ext = {{24{sign_q & rd_shift[7]}}, rd_shift[7:0]};
    end else if (type_q == TYPE_HALF) begin
      ld_ext = {{16{sign_q & rd_shift[15]}}, rd_shift[15:0]};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_illegal) begin
          state_d = ERR;
        end else if (req_go) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (mem.mem_ack) begin
          state_d = RESP;
        end else if (timeout_hit) begin
          state_d = ERR;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, timeout counter and load result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= 8'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      be_q      <= 4'd0;
      wdata_q   <= 32'd0;
      type_q    <= 4'd0;
      sign_q    <= 1'b0;
      tmo_q     <= 1'b0;
      ld_data_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= 8'd0;
          tmo_q <= 1'b0;
          if (req_go) begin
            we_q    <= req_wr_en;
            addr_q  <= {req_addr[31:2], 2'b00} | {30'd0, req_addr[1:0]};
            be_q    <= be_calc;
            wdata_q <= wdata_calc;
            type_q  <= req_ram_type;
            sign_q  <= req_sign;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 8'd1;
          if (timeout_hit) begin
            tmo_q <= 1'b1;
          end
          if (mem.mem_ack && !we_q) begin
            ld_data_q <= ld_ext;
          end
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

  // Output logic
  always_comb begin
    lsu_stall    = 1'b0;
    ld_valid     = 1'b0;
    misalign_err = 1'b0;
    timeout_err  = 1'b0;
    mem.mem_req  = 1'b0;
    case (state_q)
      IDLE:   lsu_stall = req_any;
      ACCESS: begin
        lsu_stall   = 1'b1;
        mem.mem_req = 1'b1;
      end
      RESP:   ld_valid = ~we_q;
      ERR: begin
        misalign_err = ~tmo_q;
        timeout_err  = tmo_q;
      end
      default: lsu_stall = 1'b0;
    endcase
  end

  // The bus carries the word address; addr_q keeps the byte offset for load extraction.
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = {addr_q[31:2], 2'b00};
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;
  assign ld_data       = ld_data_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed and randomized bench for lsu_mem_ctrl with a bus responder and an
// arithmetic reference model for strobes, lane data and load extension.
module tb_lsu_mem_ctrl;

  localparam int unsigned TIMEOUT = 255;
  localparam logic [3:0] T_BYTE = 4'b0001;
  localparam logic [3:0] T_HALF = 4'b0010;
  localparam logic [3:0] T_WORD = 4'b0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_rd_en = 1'b0;
  logic        req_wr_en = 1'b0;
  logic [3:0]  req_ram_type = 4'd0;
  logic        req_sign = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        lsu_stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        misalign_err;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_ld = 32'd0;

  lsu_mem_ctrl_if bus();

  lsu_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_rd_en    (req_rd_en),
    .req_wr_en    (req_wr_en),
    .req_ram_type (req_ram_type),
    .req_sign     (req_sign),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .lsu_stall    (lsu_stall),
    .ld_data      (ld_data),
    .ld_valid     (ld_valid),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err),
    .mem          (bus.master),
    .dbg_state_o  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model
  function automatic logic [3:0] m_be(input logic [3:0] t, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (t == T_BYTE) return 4'(1 << off);
    if (t == T_HALF) return 4'(3 << ((off / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] t, input logic [31:0] d);
    if (t == T_BYTE) return (d & 32'hFF) * 32'h0101_0101;
    if (t == T_HALF) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] t, input logic s,
                                         input logic [31:0] a, input logic [31:0] r);
    longint v;
    longint w;
    w = (t == T_BYTE) ? 8 : (t == T_HALF) ? 16 : 32;
    v = longint'(r) >> (8 * (a % 4));
    v = v % (64'sd1 <<< w);
    if (s && v >= (64'sd1 <<< (w - 1))) v = v - (64'sd1 <<< w);
    return 32'(v);
  endfunction

  function automatic bit m_illegal(input logic rd, input logic wr, input logic [3:0] t,
                                   input logic [31:0] a);
    return (rd && wr) || (t == T_HALF && (a % 2) != 0) || (t == T_WORD && (a % 4) != 0);
  endfunction

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_req(input logic rd, input logic wr, input logic [3:0] t,
                           input logic s, input logic [31:0] a, input logic [31:0] d);
    req_rd_en    = rd;
    req_wr_en    = wr;
    req_ram_type = t;
    req_sign     = s;
    req_addr     = a;
    req_wdata    = d;
  endtask

  task automatic clear_req();
    drive_req(1'b0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
  endtask

  // One complete access; k is the ACCESS cycle (1-based) in which mem_ack is given.
  task automatic run_req(input logic rd, input logic wr, input logic [3:0] t,
                         input logic s, input logic [31:0] a, input logic [31:0] d,
                         input int k, input logic [31:0] rdata);
    @(negedge clk);
    drive_req(rd, wr, t, s, a, d);
    #1;
    chk("stall_req_cycle", lsu_stall, 1);
    if (m_illegal(rd, wr, t, a)) begin
      @(posedge clk); #1;
      chk("misalign_err", misalign_err, 1);
      chk("misalign_stall", lsu_stall, 0);
      chk("misalign_no_req", bus.mem_req, 0);
      chk("misalign_no_tmo", timeout_err, 0);
      clear_req();
      @(posedge clk); #1;
      chk("misalign_pulse_end", misalign_err, 0);
      return;
    end
    if (rd) exp_q.push_back(m_load(t, s, a, rdata));
    @(posedge clk); #1;
    chk("mem_req", bus.mem_req, 1);
    chk("mem_we", bus.mem_we, wr);
    chk("mem_addr", bus.mem_addr, a & ~32'h3);
    chk("mem_be", bus.mem_be, m_be(t, a));
    if (wr) chk("mem_wdata", bus.mem_wdata, m_wdata(t, d));
    chk("stall_access", lsu_stall, 1);
    for (int n = 1; n < k; n++) begin
      @(posedge clk); #1;
      chk("mem_req_hold", bus.mem_req, 1);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    @(posedge clk); #1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = $urandom;
    chk("resp_no_req", bus.mem_req, 0);
    chk("resp_stall", lsu_stall, 0);
    chk("ld_valid", ld_valid, rd);
    if (rd) last_ld = exp_q.pop_front();
    chk("ld_data", ld_data, last_ld);
    clear_req();
    @(posedge clk); #1;
    chk("ld_valid_end", ld_valid, 0);
  endtask

  initial begin
    int cnt;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", dbg_state, 0);
    chk("rst_stall", lsu_stall, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_be", bus.mem_be, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // LB sign-extended from top lane; LHU upper half; SB lane 1
    run_req(1, 0, T_BYTE, 1, 32'h0000_0003, 32'd0, 1, 32'h8000_0000);
    run_req(1, 0, T_HALF, 0, 32'h0000_0002, 32'd0, 2, 32'hBEEF_1234);
    run_req(0, 1, T_BYTE, 0, 32'h0000_0101, 32'h0000_00AB, 1, 32'h1111_1111);
    chk("store_keeps_ld", ld_data, 32'h0000_BEEF);

    // Misaligned word and rd+wr collision
    run_req(1, 0, T_WORD, 0, 32'h0000_0102, 32'd0, 1, 32'd0);
    run_req(1, 1, T_WORD, 0, 32'h0000_0100, 32'd0, 1, 32'd0);

    // Unknown type is no access
    @(negedge clk);
    drive_req(1, 0, 4'b1000, 0, 32'h0000_0010, 32'd0);
    #1;
    chk("badtype_stall", lsu_stall, 0);
    @(posedge clk); #1;
    chk("badtype_no_req", bus.mem_req, 0);
    chk("badtype_no_err", misalign_err, 0);
    clear_req();

    // Bus timeout
    @(negedge clk);
    drive_req(1, 0, T_WORD, 0, 32'h0000_0040, 32'd0);
    @(posedge clk); #1;
    cnt = 0;
    while (bus.mem_req === 1'b1 && cnt < 300) begin
      cnt++;
      @(posedge clk); #1;
    end
    clear_req();
    chk("timeout_req_cycles", cnt, TIMEOUT);
    chk("timeout_err", timeout_err, 1);
    chk("timeout_mis", misalign_err, 0);
    chk("timeout_stall", lsu_stall, 0);
    @(posedge clk); #1;
    chk("timeout_pulse_end", timeout_err, 0);

    // Random accesses against the model
    for (int i = 0; i < 60; i++) begin
      int sel;
      logic [3:0] t;
      logic rd, wr;
      sel = $urandom_range(0, 2);
      t = (sel == 0) ? T_BYTE : (sel == 1) ? T_HALF : T_WORD;
      sel = $urandom_range(0, 9);
      rd = (sel <= 5);
      wr = (sel == 0) || (sel >= 6);
      run_req(rd, wr, t, 1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom_range(1, 4), $urandom);
    end

    // Reset during the third ACCESS cycle
    @(negedge clk);
    drive_req(1, 0, T_WORD, 1, 32'h0000_0080, 32'd0);
    @(posedge clk); #1;
    chk("rstmid_req", bus.mem_req, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_req();
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_ld = 32'd0;
    chk("rstmid_no_req", bus.mem_req, 0);
    chk("rstmid_state", dbg_state, 0);
    chk("rstmid_stall", lsu_stall, 0);
    chk("rstmid_ld_valid", ld_valid, 0);
    chk("rstmid_addr", bus.mem_addr, 0);
    chk("rstmid_ld_data", ld_data, 0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("late_ack_no_valid", ld_valid, 0);
    chk("late_ack_ld_data", ld_data, last_ld);
    chk("late_ack_state", dbg_state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
